bist_session_scheduler: RTL and testbench

BIST_SESSION_SCHEDULER -- requirements
Module: bist_session_scheduler

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_prio_enc.sv | 23 ++
 rtl/bist_session_scheduler.sv | 150 +++++++++++++++
 tb/tb_bist_session_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared constants and FSM encoding for the BIST session scheduler.
package bist_pkg;

  localparam int unsigned DefNumCores = 4;
  localparam int unsigned DefSigWidth = 16;
  localparam int unsigned DefTimeout  = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StLaunch,
    StWaitDone,
    StCompare,
    StFinish
  } bistState_e;

endpackage

// File: rtl/bist_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus valid.
module bist_prio_enc #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req,
  output logic [IdxW-1:0]  idx,
  output logic             valid
);

  assign valid = |req;

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/bist_session_scheduler.sv
// Sequences RTS BIST runs over the masked cores one at a time, lowest index first,
// and collects per-core pass flags and a sticky timeout flag.
module bist_session_scheduler
  import bist_pkg::*;
#(
  parameter int unsigned NUM_CORES = DefNumCores,
  parameter int unsigned SIG_WIDTH = DefSigWidth,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic                           clk,
  input  logic                           rstIn,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           core_mask,
  input  logic [NUM_CORES*SIG_WIDTH-1:0] golden_sig,
  input  logic [NUM_CORES*SIG_WIDTH-1:0] sig_in,
  input  logic [NUM_CORES-1:0]           bist_done,
  output logic [NUM_CORES-1:0]           bist_rst,
  output logic [$clog2(NUM_CORES)-1:0]   cur_core,
  output logic                           busy,
  output logic                           session_done,
  output logic [NUM_CORES-1:0]           pass_vec,
  output logic                           timeout_err
);

  localparam int unsigned IdxW = $clog2(NUM_CORES);
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  bistState_e           stateQ, stateD;
  logic [NUM_CORES-1:0] remainingQ, remainingD;
  logic [IdxW-1:0]      curCoreQ, curCoreD;
  logic [CntW-1:0]      cntQ, cntD;
  logic [NUM_CORES-1:0] bistRstQ, bistRstD;
  logic                 busyQ, busyD;
  logic                 sessionDoneQ, sessionDoneD;
  logic [NUM_CORES-1:0] passVecQ, passVecD;
  logic                 timeoutErrQ, timeoutErrD;

  logic [IdxW-1:0]      selIdx;
  logic                 selValid;
  int unsigned          sliceBase;
  logic                 sigMatch;

  bist_prio_enc #(
    .Width (NUM_CORES),
    .IdxW  (IdxW)
  ) uPrioEnc (
    .req   (remainingQ),
    .idx   (selIdx),
    .valid (selValid)
  );

  assign sliceBase = 32'(curCoreQ) * SIG_WIDTH;
  assign sigMatch  = (sig_in[sliceBase +: SIG_WIDTH] == golden_sig[sliceBase +: SIG_WIDTH]);

  // Every output is computed one cycle early and registered, so the launch pulse
  // and session_done line up exactly with the LAUNCH and FINISH states.
  always_comb begin
    stateD       = stateQ;
    remainingD   = remainingQ;
    curCoreD     = curCoreQ;
    cntD         = cntQ;
    bistRstD     = '0;
    busyD        = busyQ;
    sessionDoneD = 1'b0;
    passVecD     = passVecQ;
    timeoutErrD  = timeoutErrQ;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          remainingD  = core_mask;
          passVecD    = '0;
          timeoutErrD = 1'b0;
          busyD       = 1'b1;
          stateD      = StSelect;
        end
      end
      StSelect: begin
        if (selValid) begin
          curCoreD         = selIdx;
          bistRstD[selIdx] = 1'b1;
          stateD           = StLaunch;
        end else begin
          sessionDoneD = 1'b1;
          stateD       = StFinish;
        end
      end
      StLaunch: begin
        cntD   = '0;
        stateD = StWaitDone;
      end
      StWaitDone: begin
        cntD = cntQ + 1'b1;
        // A done arriving on the last allowed cycle still counts as done.
        if (bist_done[curCoreQ]) begin
          stateD = StCompare;
        end else if (cntQ == CntLast) begin
          timeoutErrD          = 1'b1;
          remainingD[curCoreQ] = 1'b0;
          stateD               = StSelect;
        end
      end
      StCompare: begin
        passVecD[curCoreQ]   = sigMatch;
        remainingD[curCoreQ] = 1'b0;
        stateD               = StSelect;
      end
      StFinish: begin
        busyD  = 1'b0;
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      stateQ       <= StIdle;
      remainingQ   <= '0;
      curCoreQ     <= '0;
      cntQ         <= '0;
      bistRstQ     <= '0;
      busyQ        <= 1'b0;
      sessionDoneQ <= 1'b0;
      passVecQ     <= '0;
      timeoutErrQ  <= 1'b0;
    end else begin
      stateQ       <= stateD;
      remainingQ   <= remainingD;
      curCoreQ     <= curCoreD;
      cntQ         <= cntD;
      bistRstQ     <= bistRstD;
      busyQ        <= busyD;
      sessionDoneQ <= sessionDoneD;
      passVecQ     <= passVecD;
      timeoutErrQ  <= timeoutErrD;
    end
  end

  assign bist_rst     = bistRstQ;
  assign cur_core     = curCoreQ;
  assign busy         = busyQ;
  assign session_done = sessionDoneQ;
  assign pass_vec     = passVecQ;
  assign timeout_err  = timeoutErrQ;

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Randomised bench for bist_session_scheduler: per-core BIST controller models drive done,
// and a session-level timing model predicts every output cycle by cycle.
module tb_bist_session_scheduler;

  localparam int NC = 4;
  localparam int SW = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rstIn = 1'b0;
  logic            start = 1'b0;
  logic [NC-1:0]   core_mask = '0;
  logic [NC*SW-1:0] golden_sig = '0;
  logic [NC*SW-1:0] sig_in = '0;
  logic [NC-1:0]   bist_done = '0;
  logic [NC-1:0]   bist_rst;
  logic [1:0]      cur_core;
  logic            busy;
  logic            session_done;
  logic [NC-1:0]   pass_vec;
  logic            timeout_err;

  int nChecks = 0;
  int nFails  = 0;

  // Controller environment: lat[i] is the number of WAIT_DONE cycles before done rises.
  int          lat[NC];
  logic [SW-1:0] sig[NC];
  logic [SW-1:0] gold[NC];
  bit          armed[NC];
  int          wcnt[NC];

  bist_session_scheduler #(
    .NUM_CORES (NC),
    .SIG_WIDTH (SW),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rstIn        (rstIn),
    .start        (start),
    .core_mask    (core_mask),
    .golden_sig   (golden_sig),
    .sig_in       (sig_in),
    .bist_done    (bist_done),
    .bist_rst     (bist_rst),
    .cur_core     (cur_core),
    .busy         (busy),
    .session_done (session_done),
    .pass_vec     (pass_vec),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrlStep();
    for (int i = 0; i < NC; i++) begin
      if (bist_rst[i]) begin
        armed[i]     = 1'b1;
        wcnt[i]      = 0;
        bist_done[i] = 1'b0;
      end else if (armed[i]) begin
        wcnt[i]++;
        bist_done[i] = (wcnt[i] >= lat[i]);
      end
    end
  endtask

  task automatic packSigs();
    for (int i = 0; i < NC; i++) begin
      sig_in[i*SW +: SW]     = sig[i];
      golden_sig[i*SW +: SW] = gold[i];
    end
  endtask

  // Timeline model: cycle 0 holds start; each core costs SELECT + LAUNCH + waits
  // (+ COMPARE unless it timed out); a final empty SELECT is followed by FINISH.
  task automatic runSession(input string name, input logic [NC-1:0] mask,
                            input logic [NC-1:0] doneInit, input bit junk);
    int c;
    int fin;
    int launchAt[NC];
    logic [NC-1:0] expPass;
    logic [NC-1:0] expRst;
    logic expTo;
    c = 1;
    expPass = '0;
    expTo = 1'b0;
    for (int i = 0; i < NC; i++) begin
      launchAt[i] = -1;
      if (mask[i]) begin
        launchAt[i] = c + 1;
        if (lat[i] <= TO) begin
          c += 3 + lat[i];
          expPass[i] = (sig[i] == gold[i]);
        end else begin
          c += 2 + TO;
          expTo = 1'b1;
        end
      end
    end
    fin = c + 1;

    packSigs();
    core_mask = mask;
    bist_done = doneInit;
    for (int i = 0; i < NC; i++) armed[i] = 1'b0;
    start = 1'b1;
    for (int t = 1; t <= fin + 1; t++) begin
      tick();
      ctrlStep();
      expRst = '0;
      for (int i = 0; i < NC; i++) begin
        if (launchAt[i] == t) begin
          expRst[i] = 1'b1;
          checkVal({name, ":cur_core"}, 32'(cur_core), 32'(i));
        end
      end
      checkVal({name, ":bist_rst"}, 32'(bist_rst), 32'(expRst));
      checkVal({name, ":busy"}, 32'(busy), 32'(t <= fin));
      checkVal({name, ":session_done"}, 32'(session_done), 32'(t == fin));
      if (t == 1) begin
        checkVal({name, ":pass_vec_cleared"}, 32'(pass_vec), 32'(0));
        checkVal({name, ":timeout_err_cleared"}, 32'(timeout_err), 32'(0));
      end
      if (t >= fin) begin
        checkVal({name, ":pass_vec"}, 32'(pass_vec), 32'(expPass));
        checkVal({name, ":timeout_err"}, 32'(timeout_err), 32'(expTo));
      end
      if (junk && t <= fin) begin
        start     = 1'($urandom % 2);
        core_mask = NC'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string name);
    checkVal({name, ":bist_rst"}, 32'(bist_rst), 32'(0));
    checkVal({name, ":cur_core"}, 32'(cur_core), 32'(0));
    checkVal({name, ":busy"}, 32'(busy), 32'(0));
    checkVal({name, ":session_done"}, 32'(session_done), 32'(0));
    checkVal({name, ":pass_vec"}, 32'(pass_vec), 32'(0));
    checkVal({name, ":timeout_err"}, 32'(timeout_err), 32'(0));
  endtask

  task automatic resetMid();
    lat[2]  = 100;
    sig[2]  = 16'h1234;
    gold[2] = 16'h1234;
    packSigs();
    for (int i = 0; i < NC; i++) armed[i] = 1'b0;
    bist_done = '0;
    core_mask = 4'b0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    ctrlStep();
    tick();
    ctrlStep();
    checkVal("rstmid:launch", 32'(bist_rst), 32'(4'b0100));
    repeat (2) begin
      tick();
      ctrlStep();
    end
    checkVal("rstmid:busy_before", 32'(busy), 32'(1));
    checkVal("rstmid:cur_core_before", 32'(cur_core), 32'(2));
    #1 rstIn = 1'b0;
    #1;
    checkAllZero("rstmid");
    repeat (2) begin
      tick();
      checkVal("rstmid:held_session_done", 32'(session_done), 32'(0));
    end
    rstIn = 1'b1;
    for (int i = 0; i < NC; i++) armed[i] = 1'b0;
    tick();
    checkVal("rstmid:after_busy", 32'(busy), 32'(0));
    checkVal("rstmid:after_session_done", 32'(session_done), 32'(0));
  endtask

  initial begin
    lat = '{3, 2, 5, 4};
    for (int i = 0; i < NC; i++) begin
      sig[i]  = SW'($urandom);
      gold[i] = sig[i];
      armed[i] = 1'b0;
      wcnt[i]  = 0;
    end
    repeat (2) tick();
    checkAllZero("reset");
    rstIn = 1'b1;
    tick();

    runSession("mask1010", 4'b1010, 4'b0000, 1'b0);
    runSession("busyNoise", 4'b1010, 4'b1000, 1'b1);

    lat[0]  = 2;
    sig[0]  = 16'hBEEF;
    gold[0] = 16'hBEEE;
    runSession("mismatch", 4'b0001, 4'b0000, 1'b0);

    lat[2] = 100;
    runSession("timeout", 4'b0100, 4'b0000, 1'b0);

    lat[1]  = TO;
    gold[1] = sig[1];
    runSession("doneAtLimit", 4'b0010, 4'b0000, 1'b0);

    runSession("empty", 4'b0000, 4'b1111, 1'b0);

    resetMid();
    lat = '{1, 4, 2, 3};
    for (int i = 0; i < NC; i++) gold[i] = sig[i];
    runSession("postReset", 4'b1111, 4'b0000, 1'b0);

    repeat (40) begin
      for (int i = 0; i < NC; i++) begin
        lat[i]  = $urandom_range(1, TO + 2);
        sig[i]  = SW'($urandom);
        gold[i] = ($urandom % 2) ? sig[i] : (sig[i] ^ SW'($urandom_range(1, 65535)));
      end
      runSession("rand", NC'($urandom), NC'($urandom), 1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
